// File: rtl/n64_response_decoder.sv
// N64 controller reply decoder: measures each bit's low time, assembles the 32-bit word.
// Optional: define STOP_BIT_CHECK_EN to reject a stop bit whose low time is not a short '1'.
module n64_response_decoder #(
    parameter int BIT_THRESH = 200,
    parameter int TIMEOUT    = 1000,
    parameter int NUM_BITS   = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                arm,
    input  logic                data_in,
    output logic [NUM_BITS-1:0] buttons,
    output logic                valid,
    output logic                error,
    output logic                busy
);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam int BW = $clog2(NUM_BITS + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT);
    localparam logic [CW-1:0] BIT_T   = CW'(BIT_THRESH);
    localparam logic [BW-1:0] BITS_N  = BW'(NUM_BITS);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_FALL,
        MEAS_LOW,
        DONE,
        ERR
    } state_t;

    state_t              state, state_n;
    logic [CW-1:0]       cnt, cnt_n, cnt_inc;
    logic [BW-1:0]       bitcnt, bitcnt_n;
    logic [NUM_BITS-1:0] shift, shift_n;
    logic                s1, ds, ds_d;
    logic                fall, rise;

    // Two-flop synchroniser plus one delayed copy for edge detection; idle line is high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1   <= 1'b1;
            ds   <= 1'b1;
            ds_d <= 1'b1;
        end else begin
            s1   <= data_in;
            ds   <= s1;
            ds_d <= ds;
        end
    end

    assign fall    = ds_d & ~ds;
    assign rise    = ~ds_d & ds;
    assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + CW'(1);
    assign busy    = (state != IDLE);

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        bitcnt_n = bitcnt;
        shift_n  = shift;
        unique case (state)
            IDLE: begin
                if (arm) begin
                    state_n  = WAIT_FALL;
                    cnt_n    = '0;
                    bitcnt_n = '0;
                    shift_n  = '0;
                end
            end
            WAIT_FALL: begin
                if (fall) begin
                    state_n = MEAS_LOW;
                    cnt_n   = CW'(1);
                end else if (cnt >= CNT_MAX) begin
                    state_n = ERR;
                end else begin
                    cnt_n = cnt_inc;
                end
            end
            MEAS_LOW: begin
                if (rise) begin
                    if (bitcnt < BITS_N) begin
                        shift_n  = {shift[NUM_BITS-2:0], (cnt < BIT_T)};
                        bitcnt_n = bitcnt + BW'(1);
                        cnt_n    = '0;
                        state_n  = WAIT_FALL;
                    end else begin
`ifdef STOP_BIT_CHECK_EN
                        state_n = (cnt < BIT_T) ? DONE : ERR;
`else
                        state_n = DONE;
`endif
                    end
                end else if (cnt >= CNT_MAX) begin
                    state_n = ERR;
                end else begin
                    cnt_n = cnt_inc;
                end
            end
            DONE:    state_n = IDLE;
            ERR:     state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            bitcnt  <= '0;
            shift   <= '0;
            buttons <= '0;
            valid   <= 1'b0;
            error   <= 1'b0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            bitcnt <= bitcnt_n;
            shift  <= shift_n;
            valid  <= (state == DONE);
            error  <= (state == ERR);
            if (state == DONE) begin
                buttons <= shift;
            end
        end
    end
endmodule

// File: tb/tb_n64_response_decoder.sv
// Directed bench for n64_response_decoder: decode, timeouts, threshold edge, arm/rst mid-reply.
`timescale 1ns/1ps
module tb_n64_response_decoder;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        arm = 1'b0;
    logic        data_in = 1'b1;
    logic [31:0] buttons;
    logic        valid;
    logic        error;
    logic        busy;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int vcnt = 0;
    int ecnt = 0;
    int ecyc = 0;
    int both = 0;

    n64_response_decoder dut (
        .clk(clk),
        .rst(rst),
        .arm(arm),
        .data_in(data_in),
        .buttons(buttons),
        .valid(valid),
        .error(error),
        .busy(busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (valid) vcnt = vcnt + 1;
        if (error) begin
            ecnt = ecnt + 1;
            ecyc = cyc;
        end
        if (valid && error) both = both + 1;
    end

    task automatic drive(input logic lvl, input int n);
        data_in = lvl;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_arm(output int at_cyc);
        @(posedge clk);
        #1 arm = 1'b1;
        @(posedge clk);
        #1 arm = 1'b0;
        at_cyc = cyc;
    endtask

    task automatic send_bits(input logic [31:0] w, input int nbits,
                             input int low1, input int low0,
                             input int hi1, input int hi0, input int arm_bit);
        logic b;
        int   lo;
        int   hi;
        for (int k = 0; k < nbits; k++) begin
            b  = w[31-k];
            lo = b ? low1 : low0;
            hi = b ? hi1 : hi0;
            if (k == arm_bit) begin
                data_in = 1'b0;
                arm = 1'b1;
                @(posedge clk);
                #1 arm = 1'b0;
                drive(1'b0, lo - 1);
            end else begin
                drive(1'b0, lo);
            end
            drive(1'b1, hi);
        end
    endtask

    task automatic test_reset;
        repeat (5) @(posedge clk);
        #1 rst = 1'b0;
        drive(1'b1, 5);
        checks++;
        if (buttons !== 32'h0) begin
            failures++;
            $display("FAIL reset_buttons got=%h want=%h", buttons, 32'h0);
        end
        checks++;
        if (valid !== 1'b0 || error !== 1'b0) begin
            failures++;
            $display("FAIL reset_strobes got=%b%b want=00", valid, error);
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_busy got=%b want=0", busy);
        end
    endtask

    task automatic test_basic;
        int a;
        int v0;
        int e0;
        v0 = vcnt;
        e0 = ecnt;
        pulse_arm(a);
        send_bits(32'h800000FF, 32, 100, 300, 300, 100, -1);
        drive(1'b0, 100);
        data_in = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (valid !== 1'b0) begin
            failures++;
            $display("FAIL basic_early_valid got=%b want=0", valid);
        end
        @(posedge clk);
        #1;
        checks++;
        if (valid !== 1'b1) begin
            failures++;
            $display("FAIL basic_latency_valid got=%b want=1", valid);
        end
        checks++;
        if (buttons !== 32'h800000FF) begin
            failures++;
            $display("FAIL basic_buttons got=%h want=%h", buttons, 32'h800000FF);
        end
        drive(1'b1, 20);
        checks++;
        if (vcnt - v0 !== 1 || ecnt !== e0) begin
            failures++;
            $display("FAIL basic_pulses got=v%0d,e%0d want=v1,e0", vcnt - v0, ecnt - e0);
        end
    endtask

    task automatic test_timeout;
        int a;
        int v0;
        int e0;
        v0 = vcnt;
        e0 = ecnt;
        pulse_arm(a);
        drive(1'b1, 1200);
        checks++;
        if (ecnt - e0 !== 1 || vcnt !== v0) begin
            failures++;
            $display("FAIL timeout_pulses got=e%0d,v%0d want=e1,v0", ecnt - e0, vcnt - v0);
        end
        checks++;
        if (ecyc - a < 990 || ecyc - a > 1015) begin
            failures++;
            $display("FAIL timeout_delay got=%0d want=~1000", ecyc - a);
        end
        checks++;
        if (busy !== 1'b0 || buttons !== 32'h800000FF) begin
            failures++;
            $display("FAIL timeout_hold got=%b/%h want=0/%h", busy, buttons, 32'h800000FF);
        end
    endtask

    task automatic test_midreply;
        int a;
        int v0;
        int e0;
        v0 = vcnt;
        e0 = ecnt;
        pulse_arm(a);
        send_bits(32'hFFFFFFFF, 10, 100, 300, 100, 100, -1);
        drive(1'b0, 1100);
        drive(1'b1, 50);
        checks++;
        if (ecnt - e0 !== 1 || vcnt !== v0) begin
            failures++;
            $display("FAIL mid_pulses got=e%0d,v%0d want=e1,v0", ecnt - e0, vcnt - v0);
        end
        checks++;
        if (buttons !== 32'h800000FF || busy !== 1'b0) begin
            failures++;
            $display("FAIL mid_hold got=%h/%b want=%h/0", buttons, busy, 32'h800000FF);
        end
        pulse_arm(a);
        send_bits(32'h12345678, 32, 100, 300, 100, 100, -1);
        drive(1'b0, 100);
        drive(1'b1, 20);
        checks++;
        if (buttons !== 32'h12345678 || vcnt - v0 !== 1) begin
            failures++;
            $display("FAIL mid_recover got=%h,v%0d want=%h,v1", buttons, vcnt - v0, 32'h12345678);
        end
    endtask

    task automatic test_threshold;
        int a;
        int v0;
        v0 = vcnt;
        pulse_arm(a);
        send_bits(32'hF0F0F0F0, 32, 199, 200, 100, 100, -1);
        drive(1'b0, 100);
        drive(1'b1, 20);
        checks++;
        if (buttons !== 32'hF0F0F0F0 || vcnt - v0 !== 1) begin
            failures++;
            $display("FAIL thresh got=%h,v%0d want=%h,v1", buttons, vcnt - v0, 32'hF0F0F0F0);
        end
    endtask

    task automatic test_arm_ignored;
        int a;
        int v0;
        int e0;
        v0 = vcnt;
        e0 = ecnt;
        pulse_arm(a);
        send_bits(32'hA5A5A5A5, 32, 100, 300, 100, 100, 5);
        drive(1'b0, 100);
        drive(1'b1, 20);
        checks++;
        if (buttons !== 32'hA5A5A5A5) begin
            failures++;
            $display("FAIL arm_busy_buttons got=%h want=%h", buttons, 32'hA5A5A5A5);
        end
        checks++;
        if (vcnt - v0 !== 1 || ecnt !== e0) begin
            failures++;
            $display("FAIL arm_busy_pulses got=v%0d,e%0d want=v1,e0", vcnt - v0, ecnt - e0);
        end
    endtask

    task automatic test_rst_midreply;
        int a;
        int v0;
        int e0;
        v0 = vcnt;
        e0 = ecnt;
        pulse_arm(a);
        send_bits(32'h3C3C3C3C, 20, 100, 300, 100, 100, -1);
        drive(1'b0, 50);
        rst = 1'b1;
        #1;
        checks++;
        if (buttons !== 32'h0 || valid !== 1'b0 || error !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL rst_outputs got=%h/%b%b%b want=0/000", buttons, valid, error, busy);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        drive(1'b0, 50);
        drive(1'b1, 100);
        send_bits(32'hC3C00000, 12, 100, 300, 100, 100, -1);
        drive(1'b0, 100);
        drive(1'b1, 20);
        checks++;
        if (vcnt !== v0 || ecnt !== e0 || buttons !== 32'h0) begin
            failures++;
            $display("FAIL rst_aborted got=v%0d,e%0d,%h want=v0,e0,0", vcnt - v0, ecnt - e0, buttons);
        end
    endtask

    task automatic test_stop_bit;
        int a;
        int v0;
        int e0;
        v0 = vcnt;
        e0 = ecnt;
        pulse_arm(a);
        send_bits(32'h0F0F1234, 32, 100, 300, 100, 100, -1);
        drive(1'b0, 250);
        drive(1'b1, 20);
`ifdef STOP_BIT_CHECK_EN
        checks++;
        if (ecnt - e0 !== 1 || vcnt !== v0 || buttons !== 32'h0) begin
            failures++;
            $display("FAIL stop_long got=e%0d,v%0d,%h want=e1,v0,0", ecnt - e0, vcnt - v0, buttons);
        end
`else
        checks++;
        if (vcnt - v0 !== 1 || ecnt !== e0 || buttons !== 32'h0F0F1234) begin
            failures++;
            $display("FAIL stop_long got=v%0d,e%0d,%h want=v1,e0,%h", vcnt - v0, ecnt - e0, buttons, 32'h0F0F1234);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_basic();
        test_timeout();
        test_midreply();
        test_threshold();
        test_arm_ignored();
        test_rst_midreply();
        test_stop_bit();
        checks++;
        if (both !== 0) begin
            failures++;
            $display("FAIL valid_error_overlap got=%0d want=0", both);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
